audio_demux: RTL and testbench

AUDIO_DEMUX -- requirements
Module: audio_demux

---
 rtl/audio_demux.sv | 106 ++++++++++
 tb/tb_audio_demux.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_demux.sv
// Avalon-MM stereo sample pairing into a show-ahead frame FIFO.
// Left/right writes are paired into 48-bit frames and drained by valid/ready.
module audio_demux #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     address,
  input  logic                     write,
  input  logic [31:0]              writedata,
  output logic                     waitrequest,
  output logic [23:0]              lsound_out,
  output logic [23:0]              rsound_out,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  typedef enum logic {
    IDLE,
    HAVE_L
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   left_q, left_d;
  logic          err_q, err_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q, level_d;
  logic [47:0]   mem_q [DEPTH];
  logic [47:0]   head;
  logic          full, accept, push, pop;
  logic          unused_lsb;

  assign unused_lsb = ^writedata[7:0];

  // Backpressure depends on the registered full flag only, never on a pop.
  assign full        = (level_q == FULL_LVL);
  assign waitrequest = reset |
                       (write & address & (state_q == HAVE_L) & full);
  assign accept      = write & ~waitrequest;
  assign push        = accept & address & (state_q == HAVE_L);
  assign sample_valid = (level_q != '0);
  assign pop         = sample_valid & sample_ready;

  assign head       = mem_q[rptr_q];
  assign lsound_out = sample_valid ? head[47:24] : '0;
  assign rsound_out = sample_valid ? head[23:0]  : '0;
  assign fifo_level = level_q;
  assign frame_err  = err_q;

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    err_d   = 1'b0;
    if (accept) begin
      if (!address) begin
        left_d  = writedata[31:8];
        state_d = HAVE_L;
        err_d   = (state_q == HAVE_L);
      end else if (state_q == HAVE_L) begin
        state_d = IDLE;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    unique case (1'b1)
      push && !pop: level_d = level_q + 1'b1;
      pop && !push: level_d = level_q - 1'b1;
      default:      level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      left_q  <= '0;
      err_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      err_q   <= err_d;
      wptr_q  <= wptr_q + AW'(push);
      rptr_q  <= rptr_q + AW'(pop);
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the level counter gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {left_q, writedata[31:8]};
    end
  end

endmodule

// File: tb/tb_audio_demux.sv
// Directed self-checking bench for audio_demux.
// Inputs change at posedge+1, outputs are checked at posedge+2.
module tb_audio_demux;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        address;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [23:0] lsound_out;
  logic [23:0] rsound_out;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  fifo_level;
  logic        frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  audio_demux #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .write        (write),
    .writedata    (writedata),
    .waitrequest  (waitrequest),
    .lsound_out   (lsound_out),
    .rsound_out   (rsound_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_level   (fifo_level),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got,
                     input logic [47:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [23:0] s);
    write     = 1'b1;
    address   = a;
    writedata = {s, 8'h5a};
    tick();
    write = 1'b0;
  endtask

  logic [47:0] exp_q [$];
  int          got_n;
  logic [47:0] fr;

  initial begin
    reset        = 1'b1;
    address      = 1'b0;
    write        = 1'b0;
    writedata    = '0;
    sample_ready = 1'b0;
    tick();
    #1;
    chk("rst_wait", waitrequest, 1);
    tick();
    #1;
    chk("rst_level", fifo_level, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_l", lsound_out, 0);
    reset = 1'b0;
    #1;
    chk("idle_wait", waitrequest, 0);

    // basic pair
    wr(1'b0, 24'h123456);
    wr(1'b1, 24'habcdef);
    #1;
    chk("pair_valid", sample_valid, 1);
    chk("pair_l", lsound_out, 24'h123456);
    chk("pair_r", rsound_out, 24'habcdef);
    chk("pair_level", fifo_level, 1);
    chk("pair_err", frame_err, 0);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    #1;
    chk("pop_level", fifo_level, 0);
    chk("pop_valid", sample_valid, 0);
    chk("pop_l", lsound_out, 0);

    // pairing errors
    wr(1'b1, 24'h777777);
    #1;
    chk("err_r_idle", frame_err, 1);
    chk("err_r_level", fifo_level, 0);
    tick();
    #1;
    chk("err_r_pulse", frame_err, 0);
    wr(1'b0, 24'h111111);
    #1;
    chk("err_l1", frame_err, 0);
    wr(1'b0, 24'h222222);
    #1;
    chk("err_ll", frame_err, 1);
    wr(1'b1, 24'h333333);
    #1;
    chk("err_ll_clr", frame_err, 0);
    chk("err_ll_level", fifo_level, 1);
    chk("err_ll_l", lsound_out, 24'h222222);
    chk("err_ll_r", rsound_out, 24'h333333);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;

    // fill, backpressure, order
    for (int i = 1; i <= 4; i++) begin
      wr(1'b0, 24'h100000 + 24'(i));
      wr(1'b1, 24'h200000 + 24'(i));
    end
    #1;
    chk("full_level", fifo_level, 4);
    chk("full_idle_wait", waitrequest, 0);
    wr(1'b0, 24'h100005);
    write   = 1'b1;
    address = 1'b1;
    writedata = {24'h200005, 8'h00};
    #1;
    chk("full_wait", waitrequest, 1);
    tick();
    #1;
    chk("full_hold_level", fifo_level, 4);
    chk("full_hold_wait", waitrequest, 1);
    sample_ready = 1'b1;
    #1;
    chk("full_pop_wait", waitrequest, 1);
    chk("full_head_l", lsound_out, 24'h100001);
    chk("full_head_r", rsound_out, 24'h200001);
    tick();
    sample_ready = 1'b0;
    #1;
    chk("full_pop_level", fifo_level, 3);
    chk("full_rel_wait", waitrequest, 0);
    tick();
    write = 1'b0;
    #1;
    chk("full_refill", fifo_level, 4);
    sample_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      #1;
      chk("order_l", lsound_out, 24'h100000 + 24'(i));
      chk("order_r", rsound_out, 24'h200000 + 24'(i));
      tick();
    end
    sample_ready = 1'b0;
    #1;
    chk("order_empty", fifo_level, 0);

    // simultaneous push/pop at level 2
    wr(1'b0, 24'ha00001); wr(1'b1, 24'hb00001);
    wr(1'b0, 24'ha00002); wr(1'b1, 24'hb00002);
    wr(1'b0, 24'ha00003);
    write     = 1'b1;
    address   = 1'b1;
    writedata = {24'hb00003, 8'h00};
    sample_ready = 1'b1;
    #1;
    chk("pp_head", lsound_out, 24'ha00001);
    tick();
    write        = 1'b0;
    sample_ready = 1'b0;
    #1;
    chk("pp_level", fifo_level, 2);
    chk("pp_next_l", lsound_out, 24'ha00002);
    chk("pp_next_r", rsound_out, 24'hb00002);
    sample_ready = 1'b1;
    tick();
    #1;
    chk("pp_last_l", lsound_out, 24'ha00003);
    tick();
    sample_ready = 1'b0;
    #1;
    chk("pp_empty", fifo_level, 0);

    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      wr(1'b0, 24'hc00000 + 24'(i));
      wr(1'b1, 24'hd00000 + 24'(i));
    end
    wr(1'b0, 24'heeeeee);
    #1;
    chk("mr_level3", fifo_level, 3);
    reset = 1'b1;
    #1;
    chk("mr_wait", waitrequest, 1);
    tick();
    reset = 1'b0;
    #1;
    chk("mr_level", fifo_level, 0);
    chk("mr_valid", sample_valid, 0);
    chk("mr_l", lsound_out, 0);
    chk("mr_r", rsound_out, 0);
    wr(1'b1, 24'h999999);
    #1;
    chk("mr_err", frame_err, 1);
    chk("mr_nopush", fifo_level, 0);

    // streaming across pointer wrap
    got_n        = 0;
    sample_ready = 1'b1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      for (int h = 0; h < 2; h++) begin
        write     = 1'b1;
        address   = h[0];
        writedata = h == 0 ? {24'h400000 + 24'(k), 8'h00}
                           : {24'h500000 + 24'(k), 8'h00};
        #1;
        if (sample_valid) begin
          fr = exp_q.size() > 0 ? exp_q.pop_front() : 48'hx;
          chk("wrap_frame", {lsound_out, rsound_out}, fr);
          got_n++;
        end
        tick();
        if (h == 1) exp_q.push_back({24'h400000 + 24'(k), 24'h500000 + 24'(k)});
      end
    end
    write = 1'b0;
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
      #1;
      if (sample_valid) begin
        fr = exp_q.pop_front();
        chk("wrap_drain", {lsound_out, rsound_out}, fr);
        got_n++;
      end
      tick();
    end
    sample_ready = 1'b0;
    #1;
    chk("wrap_count", 48'(got_n), 48'(3 * DEPTH));
    chk("wrap_empty", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
